// File: rtl/fb_write_arbiter_pkg.sv
// Shared mode codes, sweep FSM states and size defaults for the frame-buffer write arbiter.
// The mode encoding mirrors the st top-state codes.
package fb_write_arbiter_pkg;

    localparam int              FB_ADDR_W        = 10;
    localparam int              FB_NUM_PIX       = 1024;
    localparam int              FB_DATA_W        = 3;
    localparam logic [2:0]      FB_DEFAULT_COLOR = 3'b111;

    typedef enum logic [2:0] {
        ST_RST   = 3'd0,
        ST_SLEEP = 3'd1,
        ST_LIGHT = 3'd2,
        ST_DRAW  = 3'd3,
        ST_WRITE = 3'd4,
        ST_COLOR = 3'd5,
        ST_ERASE = 3'd6,
        ST_STOP  = 3'd7
    } st_mode_e;

    typedef enum logic {
        SW_IDLE = 1'b0,
        SW_RUN  = 1'b1
    } sweep_state_e;

    function automatic logic is_pen_mode(input logic [2:0] mode);
        return (mode == ST_DRAW) || (mode == ST_WRITE) || (mode == ST_COLOR);
    endfunction

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Request/grant and frame-buffer write bundle between the pen/eraser front-ends and the arbiter.
// The master side drives requests; the slave side (the arbiter) drives grants and the write port.
interface fb_write_arbiter_if
    import fb_write_arbiter_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W
);

    logic              pen_req;
    logic [ADDR_W-1:0] pen_addr;
    logic [DATA_W-1:0] pen_data;
    logic              pen_gnt;
    logic              erase_req;
    logic [ADDR_W-1:0] erase_addr;
    logic              erase_gnt;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [DATA_W-1:0] fb_wdata;
    logic              clr_busy;
    logic [DATA_W-1:0] color;

    modport master (
        output pen_req, pen_addr, pen_data, erase_req, erase_addr,
        input  pen_gnt, erase_gnt, fb_we, fb_addr, fb_wdata, clr_busy, color
    );

    modport slave (
        input  pen_req, pen_addr, pen_data, erase_req, erase_addr,
        output pen_gnt, erase_gnt, fb_we, fb_addr, fb_wdata, clr_busy, color
    );

endinterface

// File: rtl/fb_clear_sweep.sv
// Clear sweep engine: issues one zero-write address per cycle from 0 to NUM_PIX-1.
// A start while running rewinds to address 0; abort stops it and suppresses the current issue.
module fb_clear_sweep
    import fb_write_arbiter_pkg::*;
#(
    parameter int ADDR_W  = FB_ADDR_W,
    parameter int NUM_PIX = FB_NUM_PIX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic [ADDR_W-1:0] addr,
    output logic              we
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);

    sweep_state_e      state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SW_IDLE;
            cnt_q   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: defaults first, so no path through this block can leave a signal unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        if (abort) begin
            state_d = SW_IDLE;
            cnt_d   = '0;
        end else if (start) begin
            state_d = SW_RUN;
            cnt_d   = '0;
        end else if (state_q == SW_RUN) begin
            if (cnt_q == LAST_ADDR) begin
                state_d = SW_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign busy = (state_q == SW_RUN);
    assign addr = cnt_q;
    assign we   = busy && !abort;

endmodule

// File: rtl/fb_write_arbiter.sv
// Shares the frame-buffer write port between clear sweep, eraser and pen, gated by the st mode.
// Also holds the current pen colour, loaded by pen transfers in COLOR mode.
module fb_write_arbiter
    import fb_write_arbiter_pkg::*;
#(
    parameter int               ADDR_W        = FB_ADDR_W,
    parameter int               NUM_PIX       = FB_NUM_PIX,
    parameter int               DATA_W        = FB_DATA_W,
    parameter logic [DATA_W-1:0] DEFAULT_COLOR = FB_DEFAULT_COLOR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         state,
    input  logic [2:0]         state_deep,
    fb_write_arbiter_if.slave  bus
);

    logic [2:0]        prev_state;
    logic              sweep_start;
    logic              sweep_abort;
    logic              sweep_busy;
    logic              sweep_we;
    logic [ADDR_W-1:0] sweep_addr;
    logic              pen_write;
    logic              color_load;
    logic              unused_state_deep;

    assign unused_state_deep = ^state_deep;

    assign sweep_start = (state == ST_RST) && (prev_state != ST_RST);
    assign sweep_abort = (state == ST_STOP);

    fb_clear_sweep #(
        .ADDR_W  (ADDR_W),
        .NUM_PIX (NUM_PIX)
    ) u_sweep (
        .clk   (clk),
        .rst   (rst),
        .start (sweep_start),
        .abort (sweep_abort),
        .busy  (sweep_busy),
        .addr  (sweep_addr),
        .we    (sweep_we)
    );

    // Eraser and pen modes are disjoint, so the two grants can never both be high.
    assign bus.erase_gnt = !sweep_busy && (state == ST_ERASE) && bus.erase_req;
    assign bus.pen_gnt   = !sweep_busy && is_pen_mode(state) && bus.pen_req && !bus.erase_gnt;
    assign bus.clr_busy  = sweep_busy;

    assign color_load = bus.pen_gnt && (state == ST_COLOR);
    assign pen_write  = bus.pen_gnt && (state != ST_COLOR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_state   <= ST_STOP;
            bus.color    <= DEFAULT_COLOR;
            bus.fb_we    <= 1'b0;
            bus.fb_addr  <= '0;
            bus.fb_wdata <= '0;
        end else begin
            prev_state <= state;
            if (color_load) begin
                bus.color <= bus.pen_data;
            end
            if (sweep_we) begin
                bus.fb_we    <= 1'b1;
                bus.fb_addr  <= sweep_addr;
                bus.fb_wdata <= '0;
            end else if (bus.erase_gnt) begin
                bus.fb_we    <= 1'b1;
                bus.fb_addr  <= bus.erase_addr;
                bus.fb_wdata <= '0;
            end else if (pen_write) begin
                bus.fb_we    <= 1'b1;
                bus.fb_addr  <= bus.pen_addr;
                bus.fb_wdata <= bus.color;
            end else begin
                bus.fb_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: reset, clear sweep, mode gating, colour, erase, abort/restart, streaming.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns after that or 1 ns after the next edge.
module tb_fb_write_arbiter;
    import fb_write_arbiter_pkg::*;

    logic       clk;
    logic       rst;
    logic [2:0] state;
    logic [2:0] state_deep;
    int         checks;
    int         errors;

    fb_write_arbiter_if #(.ADDR_W(10), .DATA_W(3)) bus ();

    fb_write_arbiter #(
        .ADDR_W        (10),
        .NUM_PIX       (1024),
        .DATA_W        (3),
        .DEFAULT_COLOR (3'b111)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .state      (state),
        .state_deep (state_deep),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; state = ST_SLEEP; state_deep = 3'd0;
        bus.pen_req = 1'b0; bus.pen_addr = '0; bus.pen_data = '0;
        bus.erase_req = 1'b0; bus.erase_addr = '0;
        #12;
        checks++; if (bus.fb_we !== 1'b0) begin errors++; $display("FAIL reset_fb_we got %0b exp 0", bus.fb_we); end
        checks++; if (bus.fb_addr !== 10'h000) begin errors++; $display("FAIL reset_fb_addr got %0h exp 0", bus.fb_addr); end
        checks++; if (bus.clr_busy !== 1'b0) begin errors++; $display("FAIL reset_clr_busy got %0b exp 0", bus.clr_busy); end
        checks++; if (bus.color !== 3'b111) begin errors++; $display("FAIL reset_color got %0b exp 111", bus.color); end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_sweep();
        state = ST_SLEEP;
        tick();
        state = ST_RST;
        tick();
        checks++; if (bus.clr_busy !== 1'b1) begin errors++; $display("FAIL sweep_busy_rise got %0b exp 1", bus.clr_busy); end
        checks++; if (bus.fb_we !== 1'b0) begin errors++; $display("FAIL sweep_first_cycle_we got %0b exp 0", bus.fb_we); end
        state = ST_DRAW; bus.pen_req = 1'b1; bus.pen_addr = 10'h2AA;
        #1;
        checks++; if (bus.pen_gnt !== 1'b0) begin errors++; $display("FAIL sweep_pen_blocked got %0b exp 0", bus.pen_gnt); end
        for (int i = 0; i < 1024; i++) begin
            tick();
            checks++;
            if (bus.fb_we !== 1'b1 || bus.fb_addr !== 10'(i) || bus.fb_wdata !== 3'b000) begin
                errors++;
                $display("FAIL sweep_write[%0d] got we=%0b addr=%0h data=%0b exp we=1 addr=%0h data=0",
                         i, bus.fb_we, bus.fb_addr, bus.fb_wdata, i);
            end
            checks++;
            if (bus.clr_busy !== (i < 1023)) begin
                errors++; $display("FAIL sweep_busy[%0d] got %0b exp %0b", i, bus.clr_busy, (i < 1023));
            end
            if (i < 1023) begin
                checks++; if (bus.pen_gnt !== 1'b0) begin errors++; $display("FAIL sweep_pen_gnt[%0d] got %0b exp 0", i, bus.pen_gnt); end
            end
            if (i == 1022) bus.pen_req = 1'b0;
        end
        tick();
        checks++; if (bus.fb_we !== 1'b0) begin errors++; $display("FAIL sweep_done_we got %0b exp 0", bus.fb_we); end
        checks++; if (bus.clr_busy !== 1'b0) begin errors++; $display("FAIL sweep_done_busy got %0b exp 0", bus.clr_busy); end
    endtask

    task automatic test_mode_color_draw();
        state = ST_COLOR; bus.pen_req = 1'b1; bus.pen_data = 3'b010; bus.pen_addr = 10'h0F0;
        #1;
        checks++; if (bus.pen_gnt !== 1'b1) begin errors++; $display("FAIL color_pen_gnt got %0b exp 1", bus.pen_gnt); end
        tick();
        bus.pen_req = 1'b0;
        checks++; if (bus.fb_we !== 1'b0) begin errors++; $display("FAIL color_no_write got %0b exp 0", bus.fb_we); end
        checks++; if (bus.color !== 3'b010) begin errors++; $display("FAIL color_value got %0b exp 010", bus.color); end
        state = ST_DRAW; bus.pen_req = 1'b1; bus.pen_addr = 10'h155; bus.pen_data = 3'b101;
        #1;
        checks++; if (bus.pen_gnt !== 1'b1) begin errors++; $display("FAIL draw_pen_gnt got %0b exp 1", bus.pen_gnt); end
        tick();
        bus.pen_req = 1'b0;
        checks++;
        if (bus.fb_we !== 1'b1 || bus.fb_addr !== 10'h155 || bus.fb_wdata !== 3'b010) begin
            errors++; $display("FAIL draw_write got we=%0b addr=%0h data=%0b exp we=1 addr=155 data=010",
                               bus.fb_we, bus.fb_addr, bus.fb_wdata);
        end
        checks++; if (bus.color !== 3'b010) begin errors++; $display("FAIL draw_color_kept got %0b exp 010", bus.color); end
        tick();
        checks++; if (bus.fb_we !== 1'b0) begin errors++; $display("FAIL draw_single_pulse got %0b exp 0", bus.fb_we); end
    endtask

    task automatic test_erase_priority();
        state = ST_ERASE; bus.pen_req = 1'b1; bus.pen_addr = 10'h012;
        bus.erase_req = 1'b1; bus.erase_addr = 10'h3FF;
        #1;
        checks++; if (bus.erase_gnt !== 1'b1) begin errors++; $display("FAIL erase_gnt got %0b exp 1", bus.erase_gnt); end
        checks++; if (bus.pen_gnt !== 1'b0) begin errors++; $display("FAIL erase_pen_gnt got %0b exp 0", bus.pen_gnt); end
        tick();
        checks++;
        if (bus.fb_we !== 1'b1 || bus.fb_addr !== 10'h3FF || bus.fb_wdata !== 3'b000) begin
            errors++; $display("FAIL erase_write got we=%0b addr=%0h data=%0b exp we=1 addr=3ff data=0",
                               bus.fb_we, bus.fb_addr, bus.fb_wdata);
        end
        state = ST_LIGHT;
        #1;
        checks++;
        if (bus.pen_gnt !== 1'b0 || bus.erase_gnt !== 1'b0) begin
            errors++; $display("FAIL light_grants got pen=%0b erase=%0b exp 0 0", bus.pen_gnt, bus.erase_gnt);
        end
        tick();
        checks++; if (bus.fb_we !== 1'b0) begin errors++; $display("FAIL light_no_write got %0b exp 0", bus.fb_we); end
        bus.pen_req = 1'b0; bus.erase_req = 1'b0;
    endtask

    task automatic test_abort_restart();
        state = ST_SLEEP;
        tick();
        state = ST_RST;
        tick();
        repeat (500) tick();
        checks++;
        if (bus.fb_we !== 1'b1 || bus.fb_addr !== 10'd499) begin
            errors++; $display("FAIL abort_pre got we=%0b addr=%0d exp we=1 addr=499", bus.fb_we, bus.fb_addr);
        end
        state = ST_STOP;
        tick();
        checks++; if (bus.clr_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b exp 0", bus.clr_busy); end
        checks++; if (bus.fb_we !== 1'b0) begin errors++; $display("FAIL abort_we got %0b exp 0", bus.fb_we); end
        checks++; if (bus.color !== 3'b010) begin errors++; $display("FAIL abort_color got %0b exp 010", bus.color); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.fb_we !== 1'b0) begin errors++; $display("FAIL abort_idle_we[%0d] got %0b exp 0", i, bus.fb_we); end
        end
        state = ST_RST;
        tick();
        checks++; if (bus.clr_busy !== 1'b1) begin errors++; $display("FAIL restart_busy got %0b exp 1", bus.clr_busy); end
        tick();
        checks++;
        if (bus.fb_we !== 1'b1 || bus.fb_addr !== 10'd0) begin
            errors++; $display("FAIL restart_addr0 got we=%0b addr=%0d exp we=1 addr=0", bus.fb_we, bus.fb_addr);
        end
        tick();
        state = ST_DRAW;
        tick();
        checks++; if (bus.fb_addr !== 10'd2) begin errors++; $display("FAIL reenter_pre got %0d exp 2", bus.fb_addr); end
        state = ST_RST;
        tick();
        checks++; if (bus.fb_addr !== 10'd3) begin errors++; $display("FAIL reenter_last got %0d exp 3", bus.fb_addr); end
        tick();
        checks++;
        if (bus.fb_we !== 1'b1 || bus.fb_addr !== 10'd0) begin
            errors++; $display("FAIL reenter_restart got we=%0b addr=%0d exp we=1 addr=0", bus.fb_we, bus.fb_addr);
        end
        state = ST_STOP;
        tick();
        checks++; if (bus.clr_busy !== 1'b0) begin errors++; $display("FAIL reenter_stop got %0b exp 0", bus.clr_busy); end
    endtask

    task automatic test_back_to_back();
        state = ST_DRAW; bus.pen_req = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.pen_addr = 10'(i);
            #1;
            checks++; if (bus.pen_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt[%0d] got %0b exp 1", i, bus.pen_gnt); end
            tick();
            checks++;
            if (bus.fb_we !== 1'b1 || bus.fb_addr !== 10'(i) || bus.fb_wdata !== 3'b010) begin
                errors++; $display("FAIL b2b_write[%0d] got we=%0b addr=%0d data=%0b exp we=1 addr=%0d data=010",
                                   i, bus.fb_we, bus.fb_addr, bus.fb_wdata, i);
            end
        end
        bus.pen_req = 1'b0;
        tick();
        checks++; if (bus.fb_we !== 1'b0) begin errors++; $display("FAIL b2b_end got %0b exp 0", bus.fb_we); end
    endtask

    task automatic test_async_reset();
        state = ST_SLEEP;
        tick();
        state = ST_RST;
        tick();
        tick();
        checks++;
        if (bus.fb_we !== 1'b1 || bus.clr_busy !== 1'b1) begin
            errors++; $display("FAIL areset_pre got we=%0b busy=%0b exp 1 1", bus.fb_we, bus.clr_busy);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (bus.fb_we !== 1'b0) begin errors++; $display("FAIL areset_we got %0b exp 0", bus.fb_we); end
        checks++; if (bus.clr_busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %0b exp 0", bus.clr_busy); end
        checks++; if (bus.color !== 3'b111) begin errors++; $display("FAIL areset_color got %0b exp 111", bus.color); end
        state = ST_SLEEP;
        @(negedge clk);
        rst = 1'b1;
        tick();
        checks++; if (bus.clr_busy !== 1'b0) begin errors++; $display("FAIL areset_after got %0b exp 0", bus.clr_busy); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sweep();
        test_mode_color_draw();
        test_erase_priority();
        test_abort_restart();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
